res_acc_bram: RTL and testbench

Accumulating result buffer for the GEMV datapath. It replaces the plain result store with read-modify-write accumulation into block RAM, forwarding of back-to-back updates, a hardware clear sweep and a handshaked readout port. The tile engine streams partial sums into it, and the output/requant stage reads the finished rows out.

---
 rtl/res_acc_bram.sv | 179 +++++++++++++++++
 tb/tb_res_acc_bram.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_acc_bram.sv
// Accumulating result buffer: block-RAM read-modify-write accumulation with forwarding,
// a hardware clear sweep and a handshaked readout. Optional saturation: RES_ACC_SAT_EN.
module res_acc_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 24,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic [IN_WIDTH-1:0]   acc_data,
  input  logic                  acc_first,
  input  logic                  clr_start,
  output logic                  busy,
  input  logic                  rd_en,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ovf_sticky,
  output logic                  dbg_state
);

  // Handshakes: a request transfers on a rising edge where valid/en and ready are both high;
  // ready never depends on anything but state and acc_valid, and rd_valid is a single-cycle pulse.
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    sweep_we;
  logic                    acc_fire, rd_fire;

  logic                    s1_valid, s1_first;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [ADDR_WIDTH-1:0]   rq_addr;
  logic [DATA_WIDTH-1:0]   ram_q;
  logic                    s2_valid;
  logic [ADDR_WIDTH-1:0]   s2_addr;
  logic [DATA_WIDTH-1:0]   s2_sum;
  logic                    wr_valid;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_hold;
  logic [DATA_WIDTH-1:0]   fwd;
  logic [DATA_WIDTH-1:0]   sum;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [ADDR_WIDTH-1:0]   mem_raddr;
  logic                    mem_re;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign acc_fire  = acc_valid && acc_ready;
  assign rd_fire   = rd_en && rd_ready;
  assign dbg_state = (state == RUN);

  // In-flight pipeline writes own the write port; the sweep waits for them to drain.
  always_comb begin
    state_nxt = state;
    acc_ready = 1'b0;
    rd_ready  = 1'b0;
    busy      = 1'b0;
    sweep_we  = 1'b0;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        sweep_we = !s2_valid;
        if (sweep_we && clr_cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        acc_ready = 1'b1;
        rd_ready  = !acc_valid;
        if (clr_start) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN)  clr_cnt <= '0;
      else if (sweep_we) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  assign mem_we    = s2_valid || sweep_we;
  assign mem_waddr = s2_valid ? s2_addr : clr_cnt;
  assign mem_wdata = s2_valid ? s2_sum : '0;
  assign mem_re    = acc_fire || rd_fire;
  assign mem_raddr = acc_fire ? acc_addr : rd_addr;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) ram_q <= mem[mem_raddr];
  end

  // The RAM read misses the value being computed in S2 and the one written on the read edge.
  always_comb begin
    fwd = ram_q;
    if (s2_valid && s2_addr == rq_addr)      fwd = s2_sum;
    else if (wr_valid && wr_addr == rq_addr) fwd = wr_data;
  end

`ifdef RES_ACC_SAT_EN
  logic [DATA_WIDTH:0] wide_sum;
  logic                sat_hit;

  always_comb begin
    wide_sum = {fwd[DATA_WIDTH-1], fwd} + {s1_data[DATA_WIDTH-1], s1_data};
    sat_hit  = !s1_first && (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]);
    sum      = wide_sum[DATA_WIDTH-1:0];
    if (s1_first)     sum = s1_data;
    else if (sat_hit) sum = wide_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      ovf_sticky <= 1'b0;
    else if (state == CLEAR || state_nxt == CLEAR) ovf_sticky <= 1'b0;
    else if (s1_valid && sat_hit)                  ovf_sticky <= 1'b1;
  end
`else
  always_comb begin
    sum = s1_first ? s1_data : fwd + s1_data;
  end

  assign ovf_sticky = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      rq_addr  <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_sum   <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_valid <= 1'b0;
      rd_hold  <= '0;
    end else begin
      s1_valid <= acc_fire;
      if (acc_fire) begin
        s1_addr  <= acc_addr;
        s1_data  <= DATA_WIDTH'(signed'(acc_data));
        s1_first <= acc_first;
      end
      if (mem_re) rq_addr <= mem_raddr;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_sum  <= sum;
      end
      wr_valid <= s2_valid;
      if (s2_valid) begin
        wr_addr <= s2_addr;
        wr_data <= s2_sum;
      end
      rd_valid <= rd_fire;
      if (rd_valid) rd_hold <= fwd;
    end
  end

  assign rd_data = rd_valid ? fwd : rd_hold;

endmodule

// File: tb/tb_res_acc_bram.sv
// Bench for res_acc_bram: directed steps plus random traffic against an array model of the
// accumulator contents; honours RES_ACC_SAT_EN when defined.
module tb_res_acc_bram;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_valid, acc_ready, acc_first;
  logic [9:0]  acc_addr;
  logic [23:0] acc_data;
  logic        clr_start, busy;
  logic        rd_en, rd_ready, rd_valid;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        ovf_sticky, dbg_state;

  int               checks = 0;
  int               failures = 0;
  logic [31:0]      exp_q[$];
  logic signed [31:0] model [1024];
  logic             model_ovf;
  logic             exp_run;
  logic [31:0]      last_rd;

  res_acc_bram dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_addr(acc_addr),
    .acc_data(acc_data), .acc_first(acc_first),
    .clr_start(clr_start), .busy(busy),
    .rd_en(rd_en), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ovf_sticky(ovf_sticky), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = '0;
    model_ovf = 1'b0;
  endtask

  task automatic model_update(input int a, input logic [23:0] d, input logic f);
    longint dx, s;
    dx = longint'(signed'(d));
    if (f) model[a] = dx[31:0];
    else begin
      s = longint'(model[a]) + dx;
`ifdef RES_ACC_SAT_EN
      if (s > 64'sd2147483647) begin
        model[a] = 32'h7FFF_FFFF;
        model_ovf = 1'b1;
      end else if (s < -64'sd2147483648) begin
        model[a] = 32'h8000_0000;
        model_ovf = 1'b1;
      end else model[a] = s[31:0];
`else
      model[a] = s[31:0];
`endif
    end
  endtask

  task automatic idle();
    acc_valid = 1'b0;
    acc_first = 1'b0;
    rd_en     = 1'b0;
    clr_start = 1'b0;
  endtask

  // One clock: called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic tick();
    logic acc_acc, rd_acc, clr_acc;
    logic [31:0] e;
    #1;
    chk("acc_ready", {31'b0, acc_ready}, {31'b0, exp_run});
    chk("rd_ready", {31'b0, rd_ready}, {31'b0, exp_run && !acc_valid});
    acc_acc = acc_valid && exp_run;
    rd_acc  = rd_en && exp_run && !acc_valid;
    clr_acc = clr_start && exp_run;
    if (acc_acc) model_update(int'(acc_addr), acc_data, acc_first);
    if (rd_acc) exp_q.push_back(model[rd_addr]);
    if (clr_acc) begin
      model_clear();
      exp_run = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, rd_acc});
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL rd_extra observed=%h expected=none", rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e);
        last_rd = e;
      end
    end else chk("rd_hold", rd_data, last_rd);
  endtask

  task automatic do_acc(input int a, input logic [23:0] d, input logic f);
    acc_valid = 1'b1;
    acc_addr  = a[9:0];
    acc_data  = d;
    acc_first = f;
    tick();
    acc_valid = 1'b0;
    acc_first = 1'b0;
  endtask

  task automatic do_rd(input int a);
    rd_en   = 1'b1;
    rd_addr = a[9:0];
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    exp_run = 1'b1;
  endtask

  initial begin
    int n;
    idle();
    rst = 1'b0;
    acc_addr = '0;
    acc_data = '0;
    rd_addr = '0;
    exp_run = 1'b0;
    last_rd = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_acc_ready", {31'b0, acc_ready}, 32'd0);
    chk("reset_rd_ready", {31'b0, rd_ready}, 32'd0);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_ovf", {31'b0, ovf_sticky}, 32'd0);

    rst = 1'b1;
    wait_clear(n);
    chk("busy_cycles_reset", n, 32'd1024);
    do_rd(0);
    do_rd(511);
    do_rd(1023);

    // Same-address burst, back to back, then with one-cycle gaps.
    do_acc(7, 24'd5, 1'b1);
    repeat (3) do_acc(7, -24'sd2, 1'b0);
    do_rd(7);
    do_acc(7, 24'd5, 1'b1);
    repeat (3) begin
      tick();
      do_acc(7, -24'sd2, 1'b0);
    end
    do_rd(7);

    // Interleaved adds with a readout request held through the burst.
    rd_en = 1'b1;
    rd_addr = 10'd3;
    for (int i = 0; i < 8; i++) begin
      acc_valid = 1'b1;
      acc_first = 1'b0;
      acc_addr  = (i % 2 == 0) ? 10'd3 : 10'd4;
      acc_data  = (i % 2 == 0) ? 24'd10 : 24'd20;
      tick();
    end
    acc_valid = 1'b0;
    tick();
    rd_en = 1'b0;
    do_rd(4);

    // Read immediately after an update.
    do_acc(9, 24'd100, 1'b0);
    do_rd(9);

    // Build 0x7FFFFFF0 in entry 20, then push it past the positive limit.
    do_acc(20, 24'h7FFFFF, 1'b1);
    repeat (255) do_acc(20, 24'h7FFFFF, 1'b0);
    do_acc(20, 24'h0000F0, 1'b0);
    do_acc(20, 24'h000020, 1'b0);
    do_rd(20);
    tick();
    chk("ovf_after_overflow", {31'b0, ovf_sticky}, {31'b0, model_ovf});
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_clear(n);
    chk("ovf_after_clear", {31'b0, ovf_sticky}, {31'b0, model_ovf});
    do_rd(20);
    do_rd(9);

    // Clear with two updates still in flight.
    do_acc(12, 24'd77, 1'b1);
    acc_valid = 1'b1;
    acc_addr = 10'd30;
    acc_data = 24'($urandom);
    acc_first = 1'b1;
    tick();
    acc_addr = 10'd31;
    acc_data = 24'($urandom);
    clr_start = 1'b1;
    tick();
    idle();
    wait_clear(n);
    chk("busy_cycles_clr_drain", {31'b0, (n >= 1024 && n <= 1026)}, 32'd1);
    do_rd(30);
    do_rd(31);
    do_rd(12);
    do_rd(7);

    // Reset in the middle of a sweep, with ignored traffic during the sweep.
    clr_start = 1'b1;
    tick();
    for (int i = 0; i < 200; i++) begin
      acc_valid = 1'($urandom_range(0, 1));
      acc_addr  = 10'($urandom_range(0, 15));
      acc_data  = 24'($urandom);
      rd_en     = 1'($urandom_range(0, 1));
      rd_addr   = 10'($urandom_range(0, 15));
      clr_start = 1'($urandom_range(0, 1));
      tick();
    end
    idle();
    rst = 1'b0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    chk("midsweep_reset_busy", {31'b0, busy}, 32'd1);
    chk("midsweep_reset_rd_data", rd_data, 32'd0);
    rst = 1'b1;
    wait_clear(n);
    chk("busy_cycles_midsweep", n, 32'd1024);
    do_rd(0);
    do_rd(1023);

    // Random mixed traffic over a small address window to stress forwarding.
    for (int i = 0; i < 400; i++) begin
      acc_valid = ($urandom_range(0, 99) < 60);
      acc_addr  = 10'($urandom_range(0, 15));
      acc_data  = 24'($urandom);
      acc_first = ($urandom_range(0, 7) == 0);
      rd_en     = 1'($urandom_range(0, 1));
      rd_addr   = 10'($urandom_range(0, 15));
      tick();
    end
    idle();
    for (int a = 0; a < 16; a++) do_rd(a);
    tick();
    chk("ovf_after_random", {31'b0, ovf_sticky}, {31'b0, model_ovf});
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
